// File: rtl/lsu.sv
// Load/store unit: one valid/grant/rvalid data-memory transaction per memory op,
// with byte-lane steering for stores and sign/zero extension for loads.
module lsu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic             ex_we,
    input  logic [2:0]       ex_funct3,
    input  logic [WIDTH-1:0] ex_addr,
    input  logic [WIDTH-1:0] ex_wdata,
    output logic             lsu_busy,
    output logic             lsu_done,
    output logic             lsu_err,
    output logic [WIDTH-1:0] lsu_rdata,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [3:0]       mem_be,
    input  logic             mem_gnt,
    input  logic             mem_rvalid,
    input  logic [WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;

    state_t           state;
    logic [2:0]       funct3_q;
    logic [1:0]       off_q;
    logic             illegal;
    logic [3:0]       be_n;
    logic [WIDTH-1:0] wdata_n;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [WIDTH-1:0] ext;

    always_comb begin
        illegal = 1'b0;
        case (ex_funct3)
            3'b000, 3'b100: illegal = ex_we && ex_funct3[2];
            3'b001, 3'b101: illegal = ex_addr[0] || (ex_we && ex_funct3[2]);
            3'b010:         illegal = (ex_addr[1:0] != 2'b00);
            default:        illegal = 1'b1;
        endcase
    end

    always_comb begin
        be_n    = 4'b1111;
        wdata_n = '0;
        if (ex_we) begin
            case (ex_funct3[1:0])
                2'b00: begin
                    be_n    = 4'b0001 << ex_addr[1:0];
                    wdata_n = {4{ex_wdata[7:0]}};
                end
                2'b01: begin
                    be_n    = 4'b0011 << ex_addr[1:0];
                    wdata_n = {2{ex_wdata[15:0]}};
                end
                default: begin
                    be_n    = 4'b1111;
                    wdata_n = ex_wdata;
                end
            endcase
        end
    end

    always_comb begin
        case (off_q)
            2'b00:   byte_sel = mem_rdata[7:0];
            2'b01:   byte_sel = mem_rdata[15:8];
            2'b10:   byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  ext = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  ext = {24'h0, byte_sel};
            3'b001:  ext = {{16{half_sel[15]}}, half_sel};
            3'b101:  ext = {16'h0, half_sel};
            default: ext = mem_rdata;
        endcase
    end

    // Combinational so the instruction is held in execute from the accept cycle on.
    assign lsu_busy = ((state == IDLE) && ex_valid) || (state == REQ) || (state == RSP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            funct3_q  <= '0;
            off_q     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            lsu_done  <= 1'b0;
            lsu_err   <= 1'b0;
            lsu_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ex_valid) begin
                        funct3_q <= ex_funct3;
                        off_q    <= ex_addr[1:0];
                        if (illegal) begin
                            state    <= DONE;
                            lsu_done <= 1'b1;
                            lsu_err  <= 1'b1;
                        end else begin
                            state     <= REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= ex_we;
                            mem_addr  <= {ex_addr[WIDTH-1:2], 2'b00};
                            mem_be    <= be_n;
                            mem_wdata <= wdata_n;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        if (mem_we) begin
                            state    <= DONE;
                            lsu_done <= 1'b1;
                            lsu_err  <= 1'b0;
                        end else begin
                            state <= RSP;
                        end
                    end
                end
                RSP: begin
                    if (mem_rvalid) begin
                        state     <= DONE;
                        lsu_rdata <= ext;
                        lsu_done  <= 1'b1;
                        lsu_err   <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    lsu_done <= 1'b0;
                    lsu_err  <= 1'b0;
                end
            endcase
        end
    end

endmodule
